// File: rtl/polar2rect_pkg.sv
// polar2rect_pkg
//   Shared constants and types for the polar-to-rectangular CORDIC block.
//   - width constants for magnitude, results and angle
//   - 1/K scale factor (Q0.16) and the +90 / +180 degree angle constants
//   - FSM state encoding
//   - atan_lut(): arctangent table in degrees x1024, one entry per micro-rotation
package polar2rect_pkg;

   localparam int MAG_W = 12;
   localparam int XY_W  = 13;
   localparam int ANG_W = 19;

   // 1/K in Q0.16, K = 1.646760 (CORDIC gain for 16 micro-rotations)
   localparam logic [15:0] INV_K = 16'd39797;

   localparam logic signed [ANG_W-1:0] ANG_90  = 19'sd92160;
   localparam logic signed [ANG_W-1:0] ANG_180 = 19'sd184320;

   localparam logic signed [XY_W-1:0] XY_MAX = 13'sd4095;
   localparam logic signed [XY_W-1:0] XY_MIN = -13'sd4095;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ROT  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // round(atan(2^-idx) * 180/pi * 1024)
   function automatic logic signed [ANG_W-1:0] atan_lut(input logic [3:0] idx);
      logic signed [ANG_W-1:0] val;
      case (idx)
         4'd0:    val = 19'sd46080;
         4'd1:    val = 19'sd27203;
         4'd2:    val = 19'sd14373;
         4'd3:    val = 19'sd7296;
         4'd4:    val = 19'sd3662;
         4'd5:    val = 19'sd1833;
         4'd6:    val = 19'sd917;
         4'd7:    val = 19'sd458;
         4'd8:    val = 19'sd229;
         4'd9:    val = 19'sd115;
         4'd10:   val = 19'sd57;
         4'd11:   val = 19'sd29;
         4'd12:   val = 19'sd14;
         4'd13:   val = 19'sd7;
         4'd14:   val = 19'sd4;
         4'd15:   val = 19'sd2;
         default: val = 19'sd0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/polar2rect_cordic_rot_stage.sv
// cordic_rot_stage
//   Combinational single CORDIC micro-rotation in rotation mode.
//   Ports:
//     x_in, y_in   : current vector (signed, DP_W bits)
//     z_in         : residual angle, degrees x1024 (signed)
//     shift        : iteration index i (shift amount)
//     atan_val     : ATAN[i] for this iteration
//     x_out, y_out : rotated vector
//     z_out        : updated residual angle
module cordic_rot_stage
   import polar2rect_pkg::*;
#(
   parameter int DP_W = 18
)
(
   input  logic signed [DP_W-1:0]  x_in,
   input  logic signed [DP_W-1:0]  y_in,
   input  logic signed [ANG_W-1:0] z_in,
   input  logic [3:0]              shift,
   input  logic signed [ANG_W-1:0] atan_val,
   output logic signed [DP_W-1:0]  x_out,
   output logic signed [DP_W-1:0]  y_out,
   output logic signed [ANG_W-1:0] z_out
);

   logic signed [DP_W-1:0] x_sh_s;
   logic signed [DP_W-1:0] y_sh_s;

   // One micro-rotation: direction follows the sign of the residual angle (z >= 0 -> d = +1)
   always_comb begin
      x_sh_s = x_in >>> shift;
      y_sh_s = y_in >>> shift;
      if (z_in[ANG_W-1] == 1'b0) begin
         x_out = x_in - y_sh_s;
         y_out = y_in + x_sh_s;
         z_out = z_in - atan_val;
      end else begin
         x_out = x_in + y_sh_s;
         y_out = y_in - x_sh_s;
         z_out = z_in + atan_val;
      end
   end

endmodule

// File: rtl/polar2rect.sv
// polar2rect
//   Iterative rotation-mode CORDIC: (unsigned magnitude, signed degrees x1024)
//   -> (x, y) = mag * (cos, sin). One micro-rotation per clock.
//   Ports:
//     clock    : system clock, rising edge
//     reset    : synchronous, active-high
//     data_rdy : start strobe, mag/angle sampled on this cycle
//     mag      : unsigned magnitude 0..4095
//     angle    : signed degrees x1024, +/-184320
//     x, y     : signed results, saturated to +/-4095
//     busy     : conversion in progress
//     out_rdy  : one-cycle pulse, x/y valid from this cycle on
module polar2rect
   import polar2rect_pkg::*;
#(
   parameter int ITER  = 16,
   parameter int GUARD = 4
)
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    data_rdy,
   input  logic [MAG_W-1:0]        mag,
   input  logic signed [ANG_W-1:0] angle,
   output logic signed [XY_W-1:0]  x,
   output logic signed [XY_W-1:0]  y,
   output logic                    busy,
   output logic                    out_rdy
);

   localparam int DP_W     = MAG_W + GUARD + 2;   // internal x/y width
   localparam int DPX_W    = DP_W + 1;            // one extra bit for negate/round
   localparam int PROD_W   = MAG_W + 16;
   localparam int SCALE_SH = 16 - GUARD;
   localparam logic [3:0] LAST_ITER = 4'(ITER - 1);
   localparam logic signed [DPX_W-1:0] RND_BIAS = DPX_W'(32'sd1 <<< (GUARD - 1));
   localparam logic signed [DPX_W-1:0] SAT_HI   = DPX_W'(32'sd4095);
   localparam logic signed [DPX_W-1:0] SAT_LO   = DPX_W'(-32'sd4095);

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [MAG_W-1:0]        mag_r;
   logic signed [ANG_W-1:0] angle_r;
   logic signed [DP_W-1:0]  xi_r;
   logic signed [DP_W-1:0]  yi_r;
   logic signed [ANG_W-1:0] z_r;
   logic                    neg_r;
   logic [3:0]              iter_r;

   logic                    accept_s;
   logic signed [ANG_W-1:0] z_fold_s;
   logic                    neg_fold_s;
   logic [PROD_W-1:0]       prod_s;
   logic signed [DP_W-1:0]  x0_s;
   logic signed [ANG_W-1:0] atan_s;
   logic signed [DP_W-1:0]  xr_s;
   logic signed [DP_W-1:0]  yr_s;
   logic signed [ANG_W-1:0] zr_s;
   logic signed [DPX_W-1:0] x_fold_s;
   logic signed [DPX_W-1:0] y_fold_s;
   logic signed [DPX_W-1:0] x_sum_s;
   logic signed [DPX_W-1:0] y_sum_s;
   logic signed [DPX_W-1:0] x_rnd_s;
   logic signed [DPX_W-1:0] y_rnd_s;

   // Clamp a rounded result into the symmetric +/-4095 output range
   function automatic logic signed [XY_W-1:0] sat_xy(input logic signed [DPX_W-1:0] v);
      logic signed [XY_W-1:0] r;
      if (v > SAT_HI) begin
         r = XY_MAX;
      end else if (v < SAT_LO) begin
         r = XY_MIN;
      end else begin
         r = v[XY_W-1:0];
      end
      return r;
   endfunction

   // A request is taken only in IDLE and not in the out_rdy cycle, which still
   // closes the previous conversion (back-to-back strobes are dropped).
   assign accept_s = (state_r == ST_IDLE) && data_rdy && !out_rdy;
   assign atan_s   = atan_lut(iter_r);

   cordic_rot_stage #(.DP_W(DP_W)) u_rot (
      .x_in     (xi_r),
      .y_in     (yi_r),
      .z_in     (z_r),
      .shift    (iter_r),
      .atan_val (atan_s),
      .x_out    (xr_s),
      .y_out    (yr_s),
      .z_out    (zr_s)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: state_nxt_s = ST_ROT;
         ST_ROT: begin
            if (iter_r == LAST_ITER) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_ROT;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Quadrant fold into +/-90 degrees plus 1/K pre-scaling of the start vector
   always_comb begin
      if (angle_r > ANG_90) begin
         z_fold_s   = angle_r - ANG_180;
         neg_fold_s = 1'b1;
      end else if (angle_r < -ANG_90) begin
         z_fold_s   = angle_r + ANG_180;
         neg_fold_s = 1'b1;
      end else begin
         z_fold_s   = angle_r;
         neg_fold_s = 1'b0;
      end
      prod_s = PROD_W'(mag_r) * PROD_W'(INV_K);
      x0_s   = signed'(DP_W'(prod_s >> SCALE_SH));
   end

   // Undo the fold, round half-up, and drop the guard bits
   always_comb begin
      if (neg_r) begin
         x_fold_s = -DPX_W'(xi_r);
         y_fold_s = -DPX_W'(yi_r);
      end else begin
         x_fold_s = DPX_W'(xi_r);
         y_fold_s = DPX_W'(yi_r);
      end
      x_sum_s = x_fold_s + RND_BIAS;
      y_sum_s = y_fold_s + RND_BIAS;
      x_rnd_s = x_sum_s >>> GUARD;
      y_rnd_s = y_sum_s >>> GUARD;
   end

   // Datapath and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         mag_r   <= '0;
         angle_r <= '0;
         xi_r    <= '0;
         yi_r    <= '0;
         z_r     <= '0;
         neg_r   <= 1'b0;
         iter_r  <= 4'd0;
         x       <= '0;
         y       <= '0;
         busy    <= 1'b0;
         out_rdy <= 1'b0;
      end else begin
         out_rdy <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  mag_r   <= mag;
                  angle_r <= angle;
                  busy    <= 1'b1;
               end
            end
            ST_LOAD: begin
               xi_r   <= x0_s;
               yi_r   <= '0;
               z_r    <= z_fold_s;
               neg_r  <= neg_fold_s;
               iter_r <= 4'd0;
            end
            ST_ROT: begin
               xi_r   <= xr_s;
               yi_r   <= yr_s;
               z_r    <= zr_s;
               iter_r <= iter_r + 4'd1;
            end
            ST_DONE: begin
               x       <= sat_xy(x_rnd_s);
               y       <= sat_xy(y_rnd_s);
               out_rdy <= 1'b1;
               busy    <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
